envelope_adsr: RTL and testbench

ENVELOPE_ADSR -- requirements
Module: envelope_adsr

---
 rtl/envelope_adsr.sv | 137 +++++++++++++
 tb/tb_envelope_adsr.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_adsr.sv
// ADSR envelope generator: scales a ready/valid stream of signed samples by the envelope level.
// Optional build macro ENVELOPE_ADSR_EXP_RELEASE_EN selects an approximately exponential release tail.
module envelope_adsr #(
   parameter int SAMPLE_W = 16,
   parameter int ENV_W    = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       gate_i,
   input  logic [ENV_W-1:0]           attack_step_i,
   input  logic [ENV_W-1:0]           decay_step_i,
   input  logic [ENV_W-1:0]           sustain_level_i,
   input  logic [ENV_W-1:0]           release_step_i,
   input  logic signed [SAMPLE_W-1:0] sample_i,
   input  logic                       sample_valid_i,
   output logic                       sample_ready_o,
   output logic signed [SAMPLE_W-1:0] sample_o,
   output logic                       sample_valid_o,
   input  logic                       sample_ready_i,
   output logic [2:0]                 state_o,
   output logic [ENV_W-1:0]           level_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam int PW = SAMPLE_W + ENV_W + 1;
   localparam logic [ENV_W-1:0] FULL = '1;

   state_t                       state_q, state_d;
   logic [ENV_W-1:0]             level_q, level_d;
   logic signed [SAMPLE_W-1:0]   sample_q, sample_d;
   logic                         valid_q, valid_d;
   logic                         gate_q;
   logic                         tick;
   logic                         gate_rise;
   logic [ENV_W-1:0]             rel_dec;
   logic [ENV_W-1:0]             lv_step;

   function automatic logic [ENV_W-1:0] sat_add(input logic [ENV_W-1:0] a,
                                                 input logic [ENV_W-1:0] b);
      logic [ENV_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[ENV_W] ? FULL : s[ENV_W-1:0];
   endfunction

   // Subtract with a floor; also clamps when the level already sits below the floor.
   function automatic logic [ENV_W-1:0] floor_sub(input logic [ENV_W-1:0] a,
                                                   input logic [ENV_W-1:0] dec,
                                                   input logic [ENV_W-1:0] flr);
      if (a < dec || (a - dec) <= flr) return flr;
      return a - dec;
   endfunction

   function automatic logic signed [SAMPLE_W-1:0] scale(input logic signed [SAMPLE_W-1:0] s,
                                                         input logic [ENV_W-1:0] lv);
      logic signed [PW-1:0] se, le, p;
      se = PW'(s);
      le = $signed(PW'(lv));
      p  = se * le;
      return SAMPLE_W'(p >>> ENV_W);
   endfunction

   assign sample_ready_o = !valid_q || sample_ready_i;
   assign tick           = sample_valid_i && sample_ready_o;
   assign gate_rise      = gate_i && !gate_q;
   assign sample_o       = sample_q;
   assign sample_valid_o = valid_q;
   assign state_o        = state_q;
   assign level_o        = level_q;

`ifdef ENVELOPE_ADSR_EXP_RELEASE_EN
   assign rel_dec = (release_step_i > (level_q >> 4)) ? release_step_i : (level_q >> 4);
`else
   assign rel_dec = release_step_i;
`endif

   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      sample_d = sample_q;
      valid_d  = valid_q;
      lv_step  = level_q;

      case (state_q)
         S_IDLE:    lv_step = '0;
         S_ATTACK:  lv_step = (attack_step_i == '0) ? FULL : sat_add(level_q, attack_step_i);
         S_DECAY:   lv_step = (decay_step_i == '0) ? sustain_level_i
                                : floor_sub(level_q, decay_step_i, sustain_level_i);
         S_SUSTAIN: lv_step = sustain_level_i;
         S_RELEASE: lv_step = (release_step_i == '0) ? '0 : floor_sub(level_q, rel_dec, '0);
         default:   lv_step = '0;
      endcase

      // The product always uses the level held before this tick's update.
      if (tick) begin
         level_d  = lv_step;
         sample_d = scale(sample_i, level_q);
         valid_d  = 1'b1;
         case (state_q)
            S_ATTACK:  if (lv_step == FULL)            state_d = S_DECAY;
            S_DECAY:   if (lv_step == sustain_level_i) state_d = S_SUSTAIN;
            S_RELEASE: if (lv_step == '0)              state_d = S_IDLE;
            default:   state_d = state_q;
         endcase
      end else if (sample_ready_i) begin
         valid_d = 1'b0;
      end

      if (!gate_i && (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN))
         state_d = S_RELEASE;
      else if (gate_rise && (state_q == S_IDLE || state_q == S_RELEASE))
         state_d = S_ATTACK;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         level_q  <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         gate_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         gate_q   <= gate_i;
      end
   end

endmodule

// File: tb/tb_envelope_adsr.sv
// Bench for envelope_adsr: directed ADSR sequences plus a randomized phase checked by a reference model and sample scoreboard.
module tb_envelope_adsr;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gate = 1'b0;
   logic [15:0] attack = '0, decay = '0, sustain = '0, rel = '0;
   logic [15:0] sin = '0;
   logic        svalid = 1'b0;
   logic        sready = 1'b1;
   logic        sample_ready_o;
   logic [15:0] sample_o;
   logic        sample_valid_o;
   logic [2:0]  state_o;
   logic [15:0] level_o;

   int n_chk = 0;
   int n_pass = 0;
   int n_push = 0;
   int n_pop = 0;

   envelope_adsr #(.SAMPLE_W(16), .ENV_W(16)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .gate_i         (gate),
      .attack_step_i  (attack),
      .decay_step_i   (decay),
      .sustain_level_i(sustain),
      .release_step_i (rel),
      .sample_i       (sin),
      .sample_valid_i (svalid),
      .sample_ready_o (sample_ready_o),
      .sample_o       (sample_o),
      .sample_valid_o (sample_valid_o),
      .sample_ready_i (sready),
      .state_o        (state_o),
      .level_o        (level_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference model of the envelope, written on plain integers.
   int          m_state;
   int          m_lvl;
   logic        m_vld;
   logic        m_gprev;
   logic [15:0] exp_q[$];
   wire         m_tick = svalid && (!m_vld || sready);

   function automatic int nxt_lvl(input int st, input int lv);
      int d;
      case (st)
         1: return (attack == 0 || lv + int'(attack) >= 65535) ? 65535 : lv + int'(attack);
         2: return (decay == 0 || lv - int'(decay) <= int'(sustain)) ? int'(sustain) : lv - int'(decay);
         3: return int'(sustain);
         4: begin
            d = int'(rel);
`ifdef ENVELOPE_ADSR_EXP_RELEASE_EN
            if ((lv >> 4) > d) d = lv >> 4;
`endif
            return (rel == 0 || lv - d <= 0) ? 0 : lv - d;
         end
         default: return 0;
      endcase
   endfunction

   function automatic int nxt_st(input int st, input int lv, input logic tk, input logic g, input logic gp);
      if ((st == 1 || st == 2 || st == 3) && !g) return 4;
      if ((st == 0 || st == 4) && g && !gp) return 1;
      if (!tk) return st;
      if (st == 1 && nxt_lvl(1, lv) == 65535) return 2;
      if (st == 2 && nxt_lvl(2, lv) == int'(sustain)) return 3;
      if (st == 4 && nxt_lvl(4, lv) == 0) return 0;
      return st;
   endfunction

   function automatic logic [15:0] m_prod(input logic [15:0] s, input int lv);
      longint p;
      p = longint'($signed(s)) * longint'(lv);
      return 16'(p >>> 16);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 0;
         m_lvl   <= 0;
         m_vld   <= 1'b0;
         m_gprev <= 1'b0;
         exp_q.delete();
      end else begin
         m_gprev <= gate;
         m_state <= nxt_st(m_state, m_lvl, m_tick, gate, m_gprev);
         if (m_tick) begin
            m_lvl  <= nxt_lvl(m_state, m_lvl);
            m_vld  <= 1'b1;
            exp_q.push_back(m_prod(sin, m_lvl));
            n_push <= n_push + 1;
         end else if (sready) begin
            m_vld <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_state", 32'(state_o), 32'(m_state));
         chk("m_level", 32'(level_o), 32'(m_lvl));
         chk("m_vld", 32'(sample_valid_o), 32'(m_vld));
         chk("m_rdy", 32'(sample_ready_o), 32'(!m_vld || sready));
         if (sample_valid_o) begin
            if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            else begin
               chk("sb_sample", 32'(sample_o), 32'(exp_q[0]));
               if (sready) begin
                  void'(exp_q.pop_front());
                  n_pop <= n_pop + 1;
               end
            end
         end
      end
   end

   task automatic adv();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_env(input string tag, input int st, input int lv);
      chk({tag, "_state"}, 32'(state_o), 32'(st));
      chk({tag, "_level"}, 32'(level_o), 32'(lv));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] hold;
      rst_n = 1'b0; gate = 1'b1; svalid = 1'b1; sin = 16'h7FFF; sready = 1'b1;
      attack = 16'h4000; decay = 16'h1000; sustain = 16'hC000; rel = 16'h4000;
      adv(); adv();
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_level", 32'(level_o), 32'd0);
      chk("rst_vld", 32'(sample_valid_o), 32'd0);
      chk("rst_out", 32'(sample_o), 32'd0);
      chk("rst_rdy", 32'(sample_ready_o), 32'd1);

      // Attack
      svalid = 1'b0; rst_n = 1'b1;
      adv(); expect_env("atk0", 1, 'h0000);
      svalid = 1'b1;
      adv(); expect_env("atk1", 1, 'h4000);
      adv(); expect_env("atk2", 1, 'h8000);
      chk("atk_out2", 32'(sample_o), 32'h1FFF);
      adv(); expect_env("atk3", 1, 'hC000);
      adv(); expect_env("atk4", 2, 'hFFFF);

      // Decay into sustain
      adv(); expect_env("dec1", 2, 'hEFFF);
      adv(); expect_env("dec2", 2, 'hDFFF);
      adv(); expect_env("dec3", 2, 'hCFFF);
      adv(); expect_env("dec4", 3, 'hC000);
      adv(); expect_env("sus", 3, 'hC000);

      // Backpressure
      sready = 1'b0; sustain = 16'hB000; hold = sample_o;
      for (int i = 0; i < 5; i++) begin
         sin = 16'($urandom);
         adv();
         chk("bp_out", 32'(sample_o), 32'(hold));
         chk("bp_rdy", 32'(sample_ready_o), 32'd0);
         chk("bp_level", 32'(level_o), 32'hC000);
      end
      sready = 1'b1; sustain = 16'hC000; sin = 16'h7FFF;
      adv(); expect_env("bp_resume", 3, 'hC000);

      // Release to idle
      gate = 1'b0;
      adv(); expect_env("rel0", 4, 'hC000);
      adv(); expect_env("rel1", 4, 'h8000);
      adv(); expect_env("rel2", 4, 'h4000);
      adv(); expect_env("rel3", 0, 'h0000);
      adv(); expect_env("idle", 0, 'h0000);
      chk("idle_out", 32'(sample_o), 32'd0);

      // Retrigger during release keeps the level
      gate = 1'b1;
      adv(); expect_env("n2_atk", 1, 'h0000);
      gate = 1'b0;
      adv(); expect_env("n2_rel", 4, 'h4000);
      gate = 1'b1; svalid = 1'b0;
      adv(); expect_env("retrig", 1, 'h4000);
      svalid = 1'b1;
      adv(); expect_env("retrig1", 1, 'h8000);
      adv(); expect_env("retrig2", 1, 'hC000);
      adv(); expect_env("retrig3", 2, 'hFFFF);
      sin = 16'h8000;
      adv(); expect_env("neg", 2, 'hEFFF);
      chk("neg_out", 32'(sample_o), 32'h8000);

      // Gate edge coinciding with a tick uses the old state's arithmetic
      gate = 1'b0;
      adv(); expect_env("edge_dec", 4, 'hDFFF);
      adv(); expect_env("edge_rel", 4, 'h9FFF);
      gate = 1'b1;
      adv(); expect_env("edge_rise", 1, 'h5FFF);
      adv(); expect_env("edge_atk", 1, 'h9FFF);

      // Randomized traffic, checked by the model and scoreboard
      for (int i = 0; i < 400; i++) begin
         if (i % 25 == 0) begin
            attack  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
            decay   = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
            rel     = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
            sustain = 16'($urandom);
         end
         if ($urandom_range(0, 15) == 0) gate = ~gate;
         svalid = ($urandom_range(0, 3) != 0);
         sready = ($urandom_range(0, 3) != 0);
         sin    = 16'($urandom);
         adv();
      end
      svalid = 1'b0; sready = 1'b1;
      adv(); adv(); adv();
      chk("drain_q", 32'(exp_q.size()), 32'd0);
      chk("push_pop", 32'(n_pop), 32'(n_push));

      // Asynchronous reset mid-note
      gate = 1'b0; attack = 16'h1000; rel = 16'h0100;
      adv(); adv();
      gate = 1'b1; svalid = 1'b1;
      adv(); adv(); adv();
      rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(state_o), 32'd0);
      chk("arst_level", 32'(level_o), 32'd0);
      chk("arst_vld", 32'(sample_valid_o), 32'd0);
      chk("arst_out", 32'(sample_o), 32'd0);
      adv();
      rst_n = 1'b1;
      adv(); expect_env("post_rst0", 1, 'h0000);
      adv(); expect_env("post_rst1", 1, 'h1000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
